// File: rtl/dm_store.sv
// Word-organised data memory for the MEM stage: byte-enabled store merge,
// combinational full-word read, range/alignment flags and a registered write-commit record.
module dm_store #(
    parameter int          DEPTH     = 3072,
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] MemAddr,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  MemWriteOp,
    input  logic [31:0] WriteData,
    output logic [31:0] MemOut,
    output logic        AddrErr,
    output logic        AlignErr,
    output logic        WrValid,
    output logic [31:0] WrAddr,
    output logic [31:0] WrData
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [2:0] OP_SW = 3'b000;
    localparam logic [2:0] OP_SB = 3'b001;
    localparam logic [2:0] OP_SH = 3'b010;

    logic [31:0]      mem_q [DEPTH];
    logic [29:0]      word_off;
    logic [IDX_W-1:0] idx;
    logic             in_range;
    logic [31:0]      old_word;
    logic [3:0]       be;
    logic [31:0]      lane_data;
    logic [31:0]      merged;
    logic             commit;

    logic             wr_valid_q, wr_valid_d;
    logic [31:0]      wr_addr_q, wr_addr_d;
    logic [31:0]      wr_data_q, wr_data_d;

    // The >= test guards against the subtraction wrapping below the base into range.
    assign word_off = 30'((MemAddr - ADDR_BASE) >> 2);
    assign idx      = word_off[IDX_W-1:0];
    assign in_range = (MemAddr >= ADDR_BASE) && (word_off < 30'(DEPTH));
    assign old_word = in_range ? mem_q[idx] : 32'h0;

    always_comb begin
        be        = 4'b0000;
        lane_data = WriteData;
        case (MemWriteOp)
            OP_SW: be = 4'b1111;
            OP_SH: begin
                be        = MemAddr[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{WriteData[15:0]}};
            end
            OP_SB: begin
                be        = 4'b0001 << MemAddr[1:0];
                lane_data = {4{WriteData[7:0]}};
            end
            default: be = 4'b0000;
        endcase
    end

    always_comb begin
        merged = old_word;
        for (int k = 0; k < 4; k++) begin
            if (be[k]) merged[8*k +: 8] = lane_data[8*k +: 8];
        end
    end

    always_comb begin
        AddrErr  = (MemRead | MemWrite) & ~in_range;
        AlignErr = MemWrite & (((MemWriteOp == OP_SW) && (MemAddr[1:0] != 2'b00)) ||
                               ((MemWriteOp == OP_SH) && MemAddr[0]));
        commit   = MemWrite & in_range & ~AlignErr & (be != 4'b0000);
    end

    always_comb begin
        wr_valid_d = commit;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        if (commit) begin
            wr_addr_d = ADDR_BASE + {word_off, 2'b00};
            wr_data_d = merged;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'h0;
        end else if (commit) begin
            mem_q[idx] <= merged;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_valid_q <= 1'b0;
            wr_addr_q  <= 32'h0;
            wr_data_q  <= 32'h0;
        end else begin
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    assign MemOut  = old_word;
    assign WrValid = wr_valid_q;
    assign WrAddr  = wr_addr_q;
    assign WrData  = wr_data_q;

endmodule

// File: tb/tb_dm_store.sv
// Directed bench for dm_store: stores of each width, merges, error flags, boundaries and reset.
module tb_dm_store;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] MemAddr;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  MemWriteOp;
    logic [31:0] WriteData;
    logic [31:0] MemOut;
    logic        AddrErr;
    logic        AlignErr;
    logic        WrValid;
    logic [31:0] WrAddr;
    logic [31:0] WrData;

    int nvec = 0;
    int nerr = 0;

    dm_store #(.DEPTH(3072), .ADDR_BASE(32'h0000_0000)) dut (
        .clk        (clk),
        .reset      (reset),
        .MemAddr    (MemAddr),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .MemWriteOp (MemWriteOp),
        .WriteData  (WriteData),
        .MemOut     (MemOut),
        .AddrErr    (AddrErr),
        .AlignErr   (AlignErr),
        .WrValid    (WrValid),
        .WrAddr     (WrAddr),
        .WrData     (WrData)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive a new vector while the clock is low, then let combinational outputs settle.
    task automatic drive(input logic rst, input logic rd, input logic wr, input logic [2:0] op,
                         input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        reset      = rst;
        MemRead    = rd;
        MemWrite   = wr;
        MemWriteOp = op;
        MemAddr    = addr;
        WriteData  = data;
        #1;
    endtask

    task automatic edge_settle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; MemWriteOp = 3'b000;
        MemAddr = 32'h0; WriteData = 32'h0;
        edge_settle();
        edge_settle();

        // Post-reset read of word 0
        drive(1'b0, 1'b1, 1'b0, 3'b000, 32'h0, 32'h0);
        check("rst_memout", MemOut, 32'h0);
        check("rst_wrvalid", {31'h0, WrValid}, 32'h0);
        check("rst_addrerr", {31'h0, AddrErr}, 32'h0);
        check("rst_wraddr", WrAddr, 32'h0);

        // sw 0x12345678 at 0x4
        drive(1'b0, 1'b0, 1'b1, 3'b000, 32'h4, 32'h1234_5678);
        check("sw_same_cycle_memout", MemOut, 32'h0);
        check("sw_alignerr", {31'h0, AlignErr}, 32'h0);
        edge_settle();
        check("sw_memout", MemOut, 32'h1234_5678);
        check("sw_wrvalid", {31'h0, WrValid}, 32'h1);
        check("sw_wraddr", WrAddr, 32'h4);
        check("sw_wrdata", WrData, 32'h1234_5678);

        // sb 0xAB at 0x6, back-to-back with the sw
        drive(1'b0, 1'b0, 1'b1, 3'b001, 32'h6, 32'hFFFF_FFAB);
        check("sb6_old_word", MemOut, 32'h1234_5678);
        edge_settle();
        check("sb6_memout", MemOut, 32'h12AB_5678);
        check("sb6_wrvalid", {31'h0, WrValid}, 32'h1);
        check("sb6_wrdata", WrData, 32'h12AB_5678);

        // sb 0x01 at 0x7 on the following cycle
        drive(1'b0, 1'b0, 1'b1, 3'b001, 32'h7, 32'h0000_0001);
        edge_settle();
        check("sb7_memout", MemOut, 32'h01AB_5678);
        check("sb7_wraddr", WrAddr, 32'h4);
        check("sb7_wrvalid", {31'h0, WrValid}, 32'h1);

        // sh 0xBEEF at 0x6 (upper half)
        drive(1'b0, 1'b0, 1'b1, 3'b010, 32'h6, 32'h0000_BEEF);
        edge_settle();
        check("sh6_memout", MemOut, 32'hBEEF_5678);
        check("sh6_wrdata", WrData, 32'hBEEF_5678);

        // sh 0x1234 at 0x4 (lower half)
        drive(1'b0, 1'b0, 1'b1, 3'b010, 32'h4, 32'h5555_1234);
        edge_settle();
        check("sh4_memout", MemOut, 32'hBEEF_1234);

        // Misaligned sh at 0x5
        drive(1'b0, 1'b0, 1'b1, 3'b010, 32'h5, 32'h0000_7777);
        check("sh5_alignerr", {31'h0, AlignErr}, 32'h1);
        check("sh5_addrerr", {31'h0, AddrErr}, 32'h0);
        edge_settle();
        check("sh5_memout", MemOut, 32'hBEEF_1234);
        check("sh5_wrvalid", {31'h0, WrValid}, 32'h0);
        check("sh5_wrdata_hold", WrData, 32'hBEEF_1234);

        // Misaligned sw at 0x2
        drive(1'b0, 1'b0, 1'b1, 3'b000, 32'h2, 32'hCAFE_F00D);
        check("sw2_alignerr", {31'h0, AlignErr}, 32'h1);
        edge_settle();
        check("sw2_word0", MemOut, 32'h0);
        check("sw2_wrvalid", {31'h0, WrValid}, 32'h0);

        // sb at 0x3 is never misaligned
        drive(1'b0, 1'b0, 1'b1, 3'b001, 32'h3, 32'h0000_0099);
        check("sb3_alignerr", {31'h0, AlignErr}, 32'h0);
        edge_settle();
        check("sb3_memout", MemOut, 32'h9900_0000);

        // Last word is writable
        drive(1'b0, 1'b0, 1'b1, 3'b000, 32'h2FFC, 32'hA5A5_A5A5);
        check("last_addrerr", {31'h0, AddrErr}, 32'h0);
        edge_settle();
        check("last_memout", MemOut, 32'hA5A5_A5A5);
        check("last_wrvalid", {31'h0, WrValid}, 32'h1);
        check("last_wraddr", WrAddr, 32'h2FFC);

        // One past the end
        drive(1'b0, 1'b0, 1'b1, 3'b000, 32'h3000, 32'h1111_1111);
        check("oob_addrerr", {31'h0, AddrErr}, 32'h1);
        check("oob_memout", MemOut, 32'h0);
        edge_settle();
        check("oob_wrvalid", {31'h0, WrValid}, 32'h0);
        check("oob_wraddr_hold", WrAddr, 32'h2FFC);

        // Out-of-range load also flags
        drive(1'b0, 1'b1, 1'b0, 3'b000, 32'hFFFF_FFF0, 32'h0);
        check("oob_rd_addrerr", {31'h0, AddrErr}, 32'h1);
        check("oob_rd_alignerr", {31'h0, AlignErr}, 32'h0);

        // Invalid op: no flags, no write
        drive(1'b0, 1'b0, 1'b1, 3'b011, 32'h4, 32'h2222_2222);
        check("inv_addrerr", {31'h0, AddrErr}, 32'h0);
        check("inv_alignerr", {31'h0, AlignErr}, 32'h0);
        edge_settle();
        check("inv_memout", MemOut, 32'hBEEF_1234);
        check("inv_wrvalid", {31'h0, WrValid}, 32'h0);

        // Idle: no flags without a memory access
        drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h3000, 32'h0);
        check("idle_addrerr", {31'h0, AddrErr}, 32'h0);

        // Reset beats a simultaneous store
        drive(1'b1, 1'b0, 1'b1, 3'b000, 32'h8, 32'hDEAD_BEEF);
        edge_settle();
        check("rstwr_memout", MemOut, 32'h0);
        check("rstwr_wrvalid", {31'h0, WrValid}, 32'h0);
        check("rstwr_wraddr", WrAddr, 32'h0);
        check("rstwr_wrdata", WrData, 32'h0);

        // Earlier stores discarded by reset
        drive(1'b0, 1'b1, 1'b0, 3'b000, 32'h4, 32'h0);
        check("rst_clears_4", MemOut, 32'h0);
        drive(1'b0, 1'b1, 1'b0, 3'b000, 32'h2FFC, 32'h0);
        check("rst_clears_last", MemOut, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
